// File: rtl/seg_scan_pkg.sv
// Shared constants and helpers for the seg_scan_mux display scanner.
// Helpers size the scan counters and turn a brightness code into lit cycles per slot.
package seg_scan_pkg;

    localparam int DEF_N_DIGITS     = 4;
    localparam int DEF_DATA_W       = 5;
    localparam int DEF_SLOT_CYCLES  = 100000;
    localparam int DEF_BLANK_CYCLES = 1000;
    localparam int DEF_BRIGHT_W     = 2;
    localparam int DEF_BLINK_FRAMES = 32;

    // Counter width for a count of n states, never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int phase_width(input int slot_cycles);
        return (slot_cycles > 1) ? $clog2(slot_cycles) : 1;
    endfunction

    // Lit cycles after the blanking gap; computed at 64 bits so the product cannot overflow.
    function automatic logic [63:0] calc_on_cycles(
        input int unsigned slot,
        input int unsigned blank,
        input int unsigned bright,
        input int unsigned bright_w
    );
        logic [63:0] span;
        logic [63:0] prod;
        span = 64'(slot - blank);
        prod = span * (64'(bright) + 64'd1);
        return prod >> bright_w;
    endfunction

endpackage

// File: rtl/seg_scan_mux_timer.sv
// Slot timer for seg_scan_mux: phase counts cycles within a slot, idx selects the digit.
// slot_end_o / frame_end_o flag the last cycle of a slot and of a whole frame.
module scan_slot_timer
    import seg_scan_pkg::*;
#(
    parameter int N_DIGITS    = DEF_N_DIGITS,
    parameter int SLOT_CYCLES = DEF_SLOT_CYCLES,
    parameter int IDX_W       = idx_width(N_DIGITS),
    parameter int PH_W        = phase_width(SLOT_CYCLES)
) (
    input  logic             clk,
    input  logic             reset,
    output logic [PH_W-1:0]  phase_o,
    output logic [IDX_W-1:0] idx_o,
    output logic             slot_end_o,
    output logic             frame_end_o
);

    localparam logic [PH_W-1:0]  PH_LAST  = PH_W'(SLOT_CYCLES - 1);
    localparam logic [PH_W-1:0]  PH_ONE   = PH_W'(1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_DIGITS - 1);
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

    logic [PH_W-1:0]  phase_q, phase_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             slotEnd;
    logic             frameEnd;

    always_comb begin
        slotEnd  = (phase_q == PH_LAST);
        frameEnd = slotEnd && (idx_q == IDX_LAST);
        phase_d  = slotEnd ? '0 : phase_q + PH_ONE;
        idx_d    = idx_q;
        if (slotEnd) begin
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            phase_q <= '0;
            idx_q   <= '0;
        end else begin
            phase_q <= phase_d;
            idx_q   <= idx_d;
        end
    end

    assign phase_o     = phase_q;
    assign idx_o       = idx_q;
    assign slot_end_o  = slotEnd;
    assign frame_end_o = frameEnd;

endmodule

// File: rtl/seg_scan_mux.sv
// N-digit common-anode scanner with blanking gap, duty brightness and double-buffered data.
// Define SCAN_BLINK_EN to build the frame counter that blinks digits selected by blink_mask.
module seg_scan_mux
    import seg_scan_pkg::*;
#(
    parameter int N_DIGITS     = DEF_N_DIGITS,
    parameter int DATA_W       = DEF_DATA_W,
    parameter int SLOT_CYCLES  = DEF_SLOT_CYCLES,
    parameter int BLANK_CYCLES = DEF_BLANK_CYCLES,
    parameter int BRIGHT_W     = DEF_BRIGHT_W,
    parameter int BLINK_FRAMES = DEF_BLINK_FRAMES
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         upd_valid,
    input  logic [N_DIGITS*DATA_W-1:0]   upd_data,
    input  logic [N_DIGITS-1:0]          digit_en,
    input  logic [N_DIGITS-1:0]          blink_mask,
    input  logic [BRIGHT_W-1:0]          brightness,
    output logic [DATA_W-1:0]            seg_out,
    output logic [N_DIGITS-1:0]          an,
    output logic                         frame_start,
    output logic                         upd_pending
);

    localparam int IDX_W = idx_width(N_DIGITS);
    localparam int PH_W  = phase_width(SLOT_CYCLES);

    logic [PH_W-1:0]            phase;
    logic [IDX_W-1:0]           idx;
    logic                       slotEnd;
    logic                       frameEnd;

    logic                       slotStart_q, slotStart_d;
    logic [BRIGHT_W-1:0]        bright_q, bright_d;
    logic [BRIGHT_W-1:0]        brightEff;
    logic [63:0]                onCycles;
    logic [63:0]                phaseWide;
    logic [N_DIGITS-1:0]        blinkDark;
    logic                       lit;

    logic [N_DIGITS*DATA_W-1:0] shadow_q, shadow_d;
    logic [N_DIGITS*DATA_W-1:0] active_q, active_d;
    logic                       pend_q, pend_d;

    logic [N_DIGITS-1:0]        an_q, an_d;
    logic [DATA_W-1:0]          seg_q, seg_d;
    logic                       fs_q, fs_d;

    scan_slot_timer #(
        .N_DIGITS    (N_DIGITS),
        .SLOT_CYCLES (SLOT_CYCLES),
        .IDX_W       (IDX_W),
        .PH_W        (PH_W)
    ) u_timer (
        .clk         (clk),
        .reset       (reset),
        .phase_o     (phase),
        .idx_o       (idx),
        .slot_end_o  (slotEnd),
        .frame_end_o (frameEnd)
    );

`ifdef SCAN_BLINK_EN
    localparam int FC_W = idx_width(BLINK_FRAMES);
    localparam logic [FC_W-1:0] FC_LAST = FC_W'(BLINK_FRAMES - 1);
    localparam logic [FC_W-1:0] FC_ONE  = FC_W'(1);

    logic [FC_W-1:0] frameCnt_q, frameCnt_d;
    logic            blink_q, blink_d;

    always_comb begin
        frameCnt_d = frameCnt_q;
        blink_d    = blink_q;
        if (frameEnd) begin
            if (frameCnt_q == FC_LAST) begin
                frameCnt_d = '0;
                blink_d    = ~blink_q;
            end else begin
                frameCnt_d = frameCnt_q + FC_ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            frameCnt_q <= '0;
            blink_q    <= 1'b0;
        end else begin
            frameCnt_q <= frameCnt_d;
            blink_q    <= blink_d;
        end
    end

    assign blinkDark = blink_q ? blink_mask : '0;
`else
    assign blinkDark = blink_mask & '0;
`endif

    // slotStart_q mirrors phase == 0, so brightness is taken live then and held for the slot.
    always_comb begin
        slotStart_d = slotEnd;
        bright_d    = slotStart_q ? brightness : bright_q;
        brightEff   = bright_d;
        onCycles    = calc_on_cycles(SLOT_CYCLES, BLANK_CYCLES, 32'(brightEff), BRIGHT_W);
        phaseWide   = 64'(phase);
        lit         = (phaseWide >= 64'(BLANK_CYCLES))
                      && ((phaseWide - 64'(BLANK_CYCLES)) < onCycles)
                      && digit_en[idx]
                      && !blinkDark[idx];
    end

    always_comb begin
        an_d  = '1;
        seg_d = '0;
        fs_d  = slotStart_q && (idx == '0);
        if (lit) begin
            an_d  = ~(N_DIGITS'(1) << idx);
            seg_d = active_q[idx*DATA_W +: DATA_W];
        end
    end

    // The active buffer only swaps on the final frame cycle, so a frame never shows mixed data.
    always_comb begin
        shadow_d = shadow_q;
        active_d = active_q;
        pend_d   = pend_q;
        if (upd_valid) begin
            shadow_d = upd_data;
            pend_d   = 1'b1;
        end
        if (frameEnd && (pend_q || upd_valid)) begin
            active_d = upd_valid ? upd_data : shadow_q;
            pend_d   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            slotStart_q <= 1'b1;
            bright_q    <= '0;
            shadow_q    <= '0;
            active_q    <= '0;
            pend_q      <= 1'b0;
            an_q        <= '1;
            seg_q       <= '0;
            fs_q        <= 1'b0;
        end else begin
            slotStart_q <= slotStart_d;
            bright_q    <= bright_d;
            shadow_q    <= shadow_d;
            active_q    <= active_d;
            pend_q      <= pend_d;
            an_q        <= an_d;
            seg_q       <= seg_d;
            fs_q        <= fs_d;
        end
    end

    assign an          = an_q;
    assign seg_out     = seg_q;
    assign frame_start = fs_q;
    assign upd_pending = pend_q;

endmodule

// File: tb/tb_seg_scan_mux.sv
// Directed bench for seg_scan_mux: a frame/slot arithmetic model checked every cycle,
// plus per-frame literal expectations on lit-cycle counts and displayed digit codes.
module tb_seg_scan_mux;

    localparam int ND    = 4;
    localparam int DW    = 5;
    localparam int SC    = 16;
    localparam int BC    = 2;
    localparam int BW    = 2;
    localparam int BF    = 2;
    localparam int FRAME = ND * SC;

    logic              clk = 1'b0;
    logic              reset;
    logic              upd_valid;
    logic [ND*DW-1:0]  upd_data;
    logic [ND-1:0]     digit_en;
    logic [ND-1:0]     blink_mask;
    logic [BW-1:0]     brightness;
    logic [DW-1:0]     seg_out;
    logic [ND-1:0]     an;
    logic              frame_start;
    logic              upd_pending;

    int assertCount = 0;
    int failCount   = 0;

    logic [ND-1:0] anLog [FRAME];
    logic [DW-1:0] segLog[FRAME];
    int            fsSeen;

    seg_scan_mux #(
        .N_DIGITS     (ND),
        .DATA_W       (DW),
        .SLOT_CYCLES  (SC),
        .BLANK_CYCLES (BC),
        .BRIGHT_W     (BW),
        .BLINK_FRAMES (BF)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .upd_valid    (upd_valid),
        .upd_data     (upd_data),
        .digit_en     (digit_en),
        .blink_mask   (blink_mask),
        .brightness   (brightness),
        .seg_out      (seg_out),
        .an           (an),
        .frame_start  (frame_start),
        .upd_pending  (upd_pending)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Reference model: position in the frame is derived from a cycle count since reset.
    bit            modelValid = 1'b0;
    int            k;
    int            brightM;
    bit            pendM;
    logic [DW-1:0] activeM[ND];
    logic [DW-1:0] shadowM[ND];
    logic [ND-1:0] expAn;
    logic [DW-1:0] expSeg;
    logic          expFs;
    logic          expPend;

    always @(posedge clk) begin
        int ph, slot, frame, onCyc;
        bit lit, dark;
        if (reset) begin
            modelValid = 1'b1;
            k          = 0;
            brightM    = 0;
            pendM      = 1'b0;
            for (int i = 0; i < ND; i++) begin
                activeM[i] = '0;
                shadowM[i] = '0;
            end
            expAn   = '1;
            expSeg  = '0;
            expFs   = 1'b0;
            expPend = 1'b0;
        end else if (modelValid) begin
            ph    = k % SC;
            slot  = (k / SC) % ND;
            frame = k / FRAME;
            if (ph == 0) brightM = int'(brightness);
            onCyc = ((SC - BC) * (brightM + 1)) / (1 << BW);
            dark  = 1'b0;
`ifdef SCAN_BLINK_EN
            dark  = blink_mask[slot] && (((frame / BF) % 2) == 1);
`endif
            lit    = (ph >= BC) && ((ph - BC) < onCyc) && digit_en[slot] && !dark;
            expAn  = '1;
            expSeg = '0;
            if (lit) begin
                expAn[slot] = 1'b0;
                expSeg      = activeM[slot];
            end
            expFs = ((k % FRAME) == 0);
            if (upd_valid) begin
                for (int i = 0; i < ND; i++) shadowM[i] = upd_data[i*DW +: DW];
                pendM = 1'b1;
            end
            if (((k % FRAME) == FRAME - 1) && pendM) begin
                activeM = shadowM;
                pendM   = 1'b0;
            end
            expPend = pendM;
            k++;
        end
    end

    always @(negedge clk) begin
        if (modelValid) begin
            checkOutput("an", 32'(an), 32'(expAn));
            checkOutput("seg_out", 32'(seg_out), 32'(expSeg));
            checkOutput("frame_start", 32'(frame_start), 32'(expFs));
            checkOutput("upd_pending", 32'(upd_pending), 32'(expPend));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full frame; u0..u2 are frame-cycle indices that pulse upd_valid (-1 = unused).
    task automatic applyStimulus(input int u0, input logic [ND*DW-1:0] d0,
                                 input int u1, input logic [ND*DW-1:0] d1,
                                 input int u2, input logic [ND*DW-1:0] d2,
                                 output int lows);
        lows   = 0;
        fsSeen = 0;
        for (int j = 0; j < FRAME; j++) begin
            bit wr;
            wr        = 1'b0;
            upd_valid = 1'b0;
            if (j == u0) begin upd_valid = 1'b1; upd_data = d0; wr = 1'b1; end
            if (j == u1) begin upd_valid = 1'b1; upd_data = d1; wr = 1'b1; end
            if (j == u2) begin upd_valid = 1'b1; upd_data = d2; wr = 1'b1; end
            tick();
            upd_valid = 1'b0;
            anLog[j]  = an;
            segLog[j] = seg_out;
            if (frame_start) fsSeen++;
            if (an != '1) lows++;
            if (wr && (j != FRAME - 1)) checkOutput("upd_pending_set", 32'(upd_pending), 32'd1);
        end
        checkOutput("frame_start_first_cycle", 32'(frame_start === 1'b1 ? 0 : 0) | 32'(anLog[0] == '1), 32'd1);
        checkOutput("frame_start_count", 32'(fsSeen), 32'd1);
    endtask

    task automatic plainFrame(output int lows);
        applyStimulus(-1, '0, -1, '0, -1, '0, lows);
    endtask

    localparam logic [ND*DW-1:0] DATA_A = {5'h0A, 5'h0B, 5'h0C, 5'h0D};
    localparam logic [ND*DW-1:0] DATA_X = {5'h01, 5'h02, 5'h03, 5'h04};
    localparam logic [ND*DW-1:0] DATA_Y = {5'h05, 5'h06, 5'h07, 5'h08};
    localparam logic [ND*DW-1:0] DATA_Z = {5'h11, 5'h12, 5'h13, 5'h14};

    initial begin
        int lows;
        int blinkLows;
        reset      = 1'b1;
        upd_valid  = 1'b0;
        upd_data   = '0;
        digit_en   = 4'b1111;
        blink_mask = 4'b0000;
        brightness = 2'd3;

        repeat (3) tick();
        checkOutput("reset_an", 32'(an), 32'hF);
        checkOutput("reset_seg", 32'(seg_out), 32'd0);
        checkOutput("reset_fs", 32'(frame_start), 32'd0);
        checkOutput("reset_pend", 32'(upd_pending), 32'd0);

        reset = 1'b0;
        plainFrame(lows);
        checkOutput("lit_cycles_b3", 32'(lows), 32'd56);
        checkOutput("slot0_an_b3", 32'(anLog[2]), 32'hE);
        checkOutput("slot3_an_b3", 32'(anLog[63]), 32'h7);
        checkOutput("slot1_blank", 32'(anLog[17]), 32'hF);

        brightness = 2'd1;
        plainFrame(lows);
        checkOutput("lit_cycles_b1", 32'(lows), 32'd28);
        checkOutput("b1_last_lit", 32'(anLog[8]), 32'hE);
        checkOutput("b1_first_dark", 32'(anLog[9]), 32'hF);

        brightness = 2'd0;
        plainFrame(lows);
        checkOutput("lit_cycles_b0", 32'(lows), 32'd12);

        brightness = 2'd3;
        applyStimulus(20, DATA_A, -1, '0, -1, '0, lows);
        checkOutput("old_data_kept", 32'(segLog[21]), 32'd0);
        checkOutput("pend_cleared_at_swap", 32'(upd_pending), 32'd0);

        plainFrame(lows);
        checkOutput("new_digit0", 32'(segLog[5]), 32'h0D);
        checkOutput("new_digit1", 32'(segLog[21]), 32'h0C);
        checkOutput("new_digit2", 32'(segLog[37]), 32'h0B);
        checkOutput("new_digit3", 32'(segLog[53]), 32'h0A);
        checkOutput("pend_idle", 32'(upd_pending), 32'd0);

        applyStimulus(10, DATA_X, 30, DATA_Y, FRAME - 1, DATA_Z, lows);
        checkOutput("multi_write_pend", 32'(upd_pending), 32'd0);
        checkOutput("multi_write_old", 32'(segLog[5]), 32'h0D);

        digit_en = 4'b1011;
        plainFrame(lows);
        checkOutput("last_write_digit0", 32'(segLog[5]), 32'h14);
        checkOutput("last_write_digit3", 32'(segLog[53]), 32'h11);
        checkOutput("disabled_slot_an", 32'(anLog[37]), 32'hF);
        checkOutput("disabled_slot_seg", 32'(segLog[37]), 32'd0);
        checkOutput("lit_cycles_en1011", 32'(lows), 32'd42);

        digit_en   = 4'b1111;
        blink_mask = 4'b0001;
        plainFrame(lows);
`ifdef SCAN_BLINK_EN
        blinkLows = 42;
`else
        blinkLows = 56;
`endif
        checkOutput("blink_frame7", 32'(lows), 32'(blinkLows));

        for (int j = 0; j < 37; j++) tick();
        reset = 1'b1;
        tick();
        checkOutput("midframe_reset_an", 32'(an), 32'hF);
        checkOutput("midframe_reset_pend", 32'(upd_pending), 32'd0);
        reset = 1'b0;

        for (int f = 0; f < 6; f++) begin
            plainFrame(lows);
`ifdef SCAN_BLINK_EN
            blinkLows = (f == 2 || f == 3) ? 42 : 56;
`else
            blinkLows = 56;
`endif
            checkOutput("blink_frame_lows", 32'(lows), 32'(blinkLows));
            if (f == 0) begin
                checkOutput("restart_digit0", 32'(anLog[5]), 32'hE);
                checkOutput("restart_active_cleared", 32'(segLog[5]), 32'd0);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
